// File: rtl/mips_decode_stage.sv
// mips_decode_stage: registered MIPS-I decoder feeding a DEPTH-entry output queue.
// Define MIPS_DECODE_STATS_EN to add per-format saturating pop counters.
module mips_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_fmt,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_func,
    output logic [XLEN-1:0] out_imm,
    output logic [25:0]     out_jtarget,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
`ifdef MIPS_DECODE_STATS_EN
    ,
    output logic [15:0]     cnt_r,
    output logic [15:0]     cnt_i,
    output logic [15:0]     cnt_j,
    output logic [15:0]     cnt_ill
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]      fmt;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      func;
        logic [XLEN-1:0] imm;
        logic [25:0]     jtarget;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          dec, head;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      op;
    logic            is_r, is_i, is_j, push, pop;

    assign op   = in_instr[31:26];
    assign is_r = op == 6'd0;
    assign is_j = op == 6'd2 || op == 6'd3;
    assign is_i = op inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13,
                             6'd14, 6'd15, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};

    always_comb begin
        dec         = '0;
        dec.opcode  = op;
        dec.pc      = in_pc;
        dec.fmt     = is_r ? 2'd0 : is_i ? 2'd1 : is_j ? 2'd2 : 2'd3;
        dec.rs      = (is_r || is_i) ? in_instr[25:21] : '0;
        dec.rt      = (is_r || is_i) ? in_instr[20:16] : '0;
        dec.rd      = is_r ? in_instr[15:11] : '0;
        dec.shamt   = is_r ? in_instr[10:6] : '0;
        dec.func    = is_r ? in_instr[5:0] : '0;
        dec.jtarget = is_j ? in_instr[25:0] : '0;
        // logical immediates zero-extend; lui places the half-word high then sign-extends
        dec.imm     = !is_i ? '0 :
                      (op inside {6'd12, 6'd13, 6'd14}) ? XLEN'(in_instr[15:0]) :
                      (op == 6'd15) ? XLEN'($signed({in_instr[15:0], 16'h0000})) :
                      XLEN'($signed(in_instr[15:0]));
    end

    assign in_ready  = cnt_q != CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push && !flush) mem_q[wr_q] <= dec;
        end
    end

    assign head        = out_valid ? mem_q[rd_q] : '0;
    assign out_fmt     = head.fmt;
    assign out_opcode  = head.opcode;
    assign out_rs      = head.rs;
    assign out_rt      = head.rt;
    assign out_rd      = head.rd;
    assign out_shamt   = head.shamt;
    assign out_func    = head.func;
    assign out_imm     = head.imm;
    assign out_jtarget = head.jtarget;
    assign out_pc      = head.pc;
    assign out_illegal = head.fmt == 2'd3;

`ifdef MIPS_DECODE_STATS_EN
    logic [15:0] stat_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) stat_q[k] <= '0;
        end else if (pop && !flush && stat_q[head.fmt] != 16'hFFFF) begin
            stat_q[head.fmt] <= stat_q[head.fmt] + 16'd1;
        end
    end

    assign cnt_r   = stat_q[0];
    assign cnt_i   = stat_q[1];
    assign cnt_j   = stat_q[2];
    assign cnt_ill = stat_q[3];
`endif
endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: table-driven decode vectors plus queue, flush and reset sequences.
module tb_mips_decode_stage;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [1:0]  out_fmt;
    logic [5:0]  out_opcode, out_func;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm, out_pc;
    logic [25:0] out_jtarget;
`ifdef MIPS_DECODE_STATS_EN
    logic [15:0] cnt_r, cnt_i, cnt_j, cnt_ill;
`endif

    mips_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_func(out_func), .out_imm(out_imm), .out_jtarget(out_jtarget), .out_pc(out_pc),
        .out_illegal(out_illegal)
`ifdef MIPS_DECODE_STATS_EN
        , .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_j(cnt_j), .cnt_ill(cnt_ill)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fmt;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] jt;
    } vec_t;

    vec_t vt [13];
    int   n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] snap();
        return {2'b0, out_valid, out_fmt, out_opcode, out_rs, out_rt, out_rd, out_shamt,
                out_func, out_imm, out_jtarget, out_pc, out_illegal};
    endfunction

    function automatic logic [127:0] exp_of(input vec_t v, input logic [31:0] pc);
        return {2'b0, 1'b1, v.fmt, v.instr[31:26], v.rs, v.rt, v.rd, v.sh, v.fn, v.imm, v.jt,
                pc, v.fmt == 2'd3};
    endfunction

    task automatic flow(input vec_t v, input logic [31:0] pc, input string name);
        in_valid  = 1;
        in_instr  = v.instr;
        in_pc     = pc;
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        check(name, snap(), exp_of(v, pc));
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{32'h012A4020, 2'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0, 26'h0};
        vt[1]  = '{32'h000940C0, 2'd0, 5'd0, 5'd9, 5'd8, 5'd3, 6'h00, 32'h0, 26'h0};
        vt[2]  = '{32'h2128FFFF, 2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFF, 26'h0};
        vt[3]  = '{32'h3528FFFF, 2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'h0000FFFF, 26'h0};
        vt[4]  = '{32'h3C081234, 2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 32'h12340000, 26'h0};
        vt[5]  = '{32'h3C088000, 2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 32'h80000000, 26'h0};
        vt[6]  = '{32'h31288000, 2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'h00008000, 26'h0};
        vt[7]  = '{32'h8D09FFFC, 2'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFC, 26'h0};
        vt[8]  = '{32'h1109FFFE, 2'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFE, 26'h0};
        vt[9]  = '{32'h0C100004, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0100004};
        vt[10] = '{32'hFC000000, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0};
        vt[11] = '{32'h04A1FFFF, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0};
        vt[12] = '{32'h7D2A4020, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0};

        repeat (2) @(negedge clk);
        check("reset_outputs", snap(), '0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) flow(vt[i], 32'h1000 + 32'(i) * 4, $sformatf("vec%0d", i));
        check("drained", 128'(out_valid), 128'd0);

        // backpressure: fill, stall, single pop while full must not admit a push
        out_ready = 0;
        in_valid  = 1;
        in_instr  = vt[0].instr;
        in_pc     = 32'h2000;
        @(negedge clk);
        check("bp_first_ready", 128'(in_ready), 128'd1);
        in_instr = vt[2].instr;
        in_pc    = 32'h2004;
        @(negedge clk);
        check("bp_full_ready", 128'(in_ready), 128'd0);
        check("bp_head_a", snap(), exp_of(vt[0], 32'h2000));
        in_instr = vt[3].instr;
        in_pc    = 32'h2008;
        @(negedge clk);
        check("bp_head_stable", snap(), exp_of(vt[0], 32'h2000));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("bp_ready_after_pop", 128'(in_ready), 128'd1);
        check("bp_head_b", snap(), exp_of(vt[2], 32'h2004));
        @(negedge clk);
        in_valid = 0;
        check("bp_refull", 128'(in_ready), 128'd0);
        out_ready = 1;
        @(negedge clk);
        check("bp_head_c", snap(), exp_of(vt[3], 32'h2008));
        @(negedge clk);
        check("bp_empty", 128'(out_valid), 128'd0);

        // flush with two entries and a concurrent push request
        out_ready = 0;
        in_valid  = 1;
        in_instr  = vt[1].instr;
        in_pc     = 32'h3000;
        repeat (2) @(negedge clk);
        check("fl_two_held", 128'(in_ready), 128'd0);
        flush = 1;
        @(negedge clk);
        flush    = 0;
        in_valid = 0;
        check("fl_two_valid", 128'(out_valid), 128'd0);
        check("fl_two_ready", 128'(in_ready), 128'd1);

        // flush beats push and pop when the queue is not full
        in_valid = 1;
        @(negedge clk);
        flush     = 1;
        out_ready = 1;
        @(negedge clk);
        flush     = 0;
        in_valid  = 0;
        check("fl_one_valid", snap(), '0);
        @(negedge clk);
        check("fl_nothing_pushed", 128'(out_valid), 128'd0);

        // asynchronous reset mid-stream
        out_ready = 0;
        in_valid  = 1;
        in_instr  = vt[4].instr;
        in_pc     = 32'h4000;
        @(negedge clk);
        in_valid = 0;
        check("ar_loaded", snap(), exp_of(vt[4], 32'h4000));
        #2 rst_n = 0;
        #1;
        check("ar_outputs", snap(), '0);
        check("ar_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("ar_still_empty", 128'(out_valid), 128'd0);

`ifdef MIPS_DECODE_STATS_EN
        flow(vt[0], 32'h5000, "st_r0");
        flow(vt[1], 32'h5004, "st_r1");
        flow(vt[0], 32'h5008, "st_r2");
        flow(vt[2], 32'h500C, "st_i0");
        flow(vt[3], 32'h5010, "st_i1");
        flow(vt[10], 32'h5014, "st_ill");
        check("st_counts", 128'({cnt_r, cnt_i, cnt_j, cnt_ill}),
              128'({16'd3, 16'd2, 16'd0, 16'd1}));
        in_valid  = 1;
        out_ready = 1;
        in_instr  = vt[0].instr;
        repeat (65540) @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        check("st_saturate", 128'({cnt_r, cnt_i}), 128'({16'hFFFF, 16'd2}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- Registered MIPS-I decode stage with valid/ready handshake and a DEPTH-entry output queue.
- Successor to the single-register negedge decoder. Adds:
  - J-format support
  - a wider I-format opcode set
  - XLEN-wide extended immediate
  - illegal-opcode flagging
  - PC tagging, flush and backpressure
- Sits between fetch and register-read/execute.

Parameters:
- XLEN, 32: width of extended immediate output; legal values 32 or 64.
- PC_W, 32: width of the PC tag carried alongside each instruction.
- DEPTH, 2: output queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; empties the queue.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_fmt  out  2  0=R, 1=I, 2=J, 3=illegal.
- out_opcode  out  6  instr[31:26].
- out_rs, out_rt, out_rd, out_shamt  out  5 each  register and shift fields.
- out_func  out  6  instr[5:0].
- out_imm  out  XLEN  extended immediate.
- out_jtarget  out  26  instr[25:0].
- out_pc  out  PC_W  PC tag.
- out_illegal  out  1  equals (out_fmt==3).

Behaviour:
- Reset (rst_n low, async): read/write pointers 0, occupancy 0, all queue entries 0. in_ready=1, out_valid=0, every out_* field =0. Reset mid-stream discards all entries.
- Push:
  - Happens on an edge where in_valid && in_ready.
  - Decode is combinational on in_instr; the decoded record plus in_pc is written to the tail.
  - Latency: the instruction is visible on out_* the next cycle if the queue was empty.
- Pop: happens on an edge where out_valid && out_ready. Head advances; pointers wrap modulo DEPTH.
- in_ready = (occupancy != DEPTH). No combinational path from out_ready to in_ready.
  - When full, a simultaneous pop does not allow a push that cycle.
- Push and pop in the same cycle (not full, not empty): occupancy unchanged.
- out_valid = (occupancy != 0). out_* fields show the head entry. Fields hold value while out_valid && !out_ready.
- flush: occupancy and pointers return to 0 at the edge. flush has priority over push and pop that cycle. out_valid=0 the next cycle.
- Format classification:
  - opcode 0 -> R.
  - opcode 2 or 3 -> J.
  - opcode in {4,5,6,7,8,9,10,11,12,13,14,15,32,33,35,36,37,40,41,43} -> I.
  - all others -> illegal.
- Field zeroing:
  - R: rs, rt, rd, shamt, func from the word; imm=0, jtarget=0.
  - I: rs, rt, imm from the word; rd, shamt, func, jtarget=0.
  - J: jtarget from the word; all register fields, func and imm =0.
  - Illegal: opcode kept, all other fields 0.
- Immediate extension:
  - Opcodes 12, 13, 14 (andi/ori/xori): zero-extend instr[15:0] to XLEN.
  - Opcode 15 (lui): instr[15:0] << 16, sign-extended to XLEN.
  - All other I-format opcodes: sign-extend instr[15:0].

Optional Feature:
- Macro MIPS_DECODE_STATS_EN.
- Defined:
  - Adds output ports cnt_r, cnt_i, cnt_j, cnt_ill, each 16 bits.
  - Each counter increments on a pop whose head has the matching out_fmt.
  - Counters saturate at 0xFFFF.
  - Reset clears them to 0; flush does not clear them.
- Not defined: ports and counters absent; no other behaviour changes.

Test Plan:
- Reset then push 0x012A4020 (add $8,$9,$10), out_ready=1 -> next cycle: out_valid=1, fmt=0, rs=9, rt=10, rd=8, shamt=0, func=0x20, imm=0.
- Push 0x2128FFFF (addi) -> fmt=1, imm=0xFFFFFFFF. Push 0x3528FFFF (ori) -> imm=0x0000FFFF. Push 0x3C081234 (lui) -> imm=0x12340000.
- Push 0x0C100004 (jal) -> fmt=2, jtarget=0x0100004, rs=rt=rd=0. Push 0xFC000000 -> fmt=3, out_illegal=1, other fields 0.
- Hold out_ready=0, push DEPTH instructions -> in_ready=0 after the DEPTH-th push, head stable. Assert out_ready for 1 cycle -> in_ready=1 next cycle, order preserved.
- Queue holds 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, nothing pushed. Pull rst_n low mid-stream -> all outputs 0 immediately.
- With MIPS_DECODE_STATS_EN: pop 3 R-format, 2 I-format, 1 illegal -> cnt_r=3, cnt_i=2, cnt_j=0, cnt_ill=1. Preload a counter to 0xFFFF and pop one more -> it stays 0xFFFF.
